pipe_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage CPU. It sits beside the IF/ID/EX/MEM/WB registers and drives their write-enables, flushes and bubbles.

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its hazard comparators.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_MWAIT = 2'd2
    } pipe_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is about to write.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem2reg_i,
    input  logic                  ex_reg_wr_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_i,
    output logic                  load_use_o
);
    logic rs_hit;
    logic rt_hit;
    logic ex_load_wr;

    // Writes to register zero are discarded, so they never create a dependence.
    assign ex_load_wr = ex_mem2reg_i && ex_reg_wr_i && (ex_dst_i != REG_ADDR_W'(REG_ZERO));
    assign rs_hit     = (ex_dst_i == id_rs_i);
    assign rt_hit     = id_uses_rt_i && (ex_dst_i == id_rt_i);
    assign load_use_o = ex_load_wr && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives the pipeline register enables, flushes and bubbles for
// load-use stalls, EX-resolved redirects and data-memory wait states; keeps debug counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_WAIT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem2reg_i,
    input  logic                  ex_reg_wr_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_req_i,
    output logic                  pc_wr_en_o,
    output logic                  ifid_wr_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_wr_en_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_wr_en_o,
    output logic                  memwb_bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output pipe_state_t           state_o
);
    localparam int              WCNT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam bit              HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    pipe_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic load_use;
    logic freeze;
    logic do_redirect;
    logic do_stall;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_mem2reg_i (ex_mem2reg_i),
        .ex_reg_wr_i  (ex_reg_wr_i),
        .ex_dst_i     (ex_dst_i),
        .load_use_o   (load_use)
    );

    // The release cycle of S_MWAIT is not a freeze, so held redirects/load-uses act there.
    assign freeze = ((state_q == S_RUN) && mem_req_i && HAS_WAIT) ||
                    ((state_q == S_MWAIT) && (wcnt_q != '0));
    assign do_redirect = (state_q != S_HOLD) && !freeze && ex_redirect_i;
    assign do_stall    = (state_q != S_HOLD) && !freeze && !ex_redirect_i && load_use;

    always_comb begin
        pc_wr_en_o     = 1'b1;
        ifid_wr_en_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_wr_en_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_wr_en_o  = 1'b1;
        memwb_bubble_o = 1'b0;
        if (state_q == S_HOLD) begin
            pc_wr_en_o     = 1'b0;
            ifid_wr_en_o   = 1'b0;
            exmem_wr_en_o  = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (freeze) begin
            pc_wr_en_o     = 1'b0;
            ifid_wr_en_o   = 1'b0;
            idex_wr_en_o   = 1'b0;
            exmem_wr_en_o  = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (do_redirect) begin
            ifid_flush_o   = 1'b1;
            idex_bubble_o  = 1'b1;
        end else if (do_stall) begin
            pc_wr_en_o     = 1'b0;
            ifid_wr_en_o   = 1'b0;
            idex_bubble_o  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_HOLD: state_d = S_RUN;
            S_RUN: begin
                if (mem_req_i && HAS_WAIT) begin
                    state_d = S_MWAIT;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            S_MWAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_HOLD;
        endcase

        stall_d = stall_q;
        flush_d = flush_q;
        if ((freeze || do_stall) && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (do_redirect && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLD;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign state_o     = state_q;
endmodule
